// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fb_pkg
//  Description : Shared geometry, address width, FSM encoding, port-owner
//                encoding and write-entry type for the frame buffer arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam int FB_W       = 20;
    localparam int FB_H       = 20;
    localparam int FB_DEPTH   = FB_W * FB_H;
    localparam int ADDR_W     = (FB_DEPTH <= 2) ? 1 : $clog2(FB_DEPTH);
    localparam int COORD_W    = 5;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fb_state_e;

    typedef enum logic [1:0] {
        OWN_RD   = 2'd0,
        OWN_CLR  = 2'd1,
        OWN_WR   = 2'd2,
        OWN_NONE = 2'd3
    } fb_owner_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              color;
        logic              in_range;
    } fb_wr_entry_t;

    // Row-major linear address, evaluated ADDR_W bits wide.
    function automatic logic [ADDR_W-1:0] fb_lin_addr(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y
    );
        return ADDR_W'(x) + ADDR_W'(FB_W) * ADDR_W'(y);
    endfunction

    function automatic logic fb_in_range(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y
    );
        return (32'(x) < FB_W) && (32'(y) < FB_H);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Interface   : fb_arbiter_if
//  Description : Renderer write channel, VGA scan-out channel, clear control
//                and RAM bus of the frame buffer arbiter.
//                slave  = arbiter side, master = surrounding system side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fb_arbiter_if;
    import fb_pkg::*;

    logic               clr_screen;
    logic               clr_busy;
    logic               wr_valid;
    logic               wr_ready;
    logic [COORD_W-1:0] wr_x;
    logic [COORD_W-1:0] wr_y;
    logic               wr_color;
    logic               rd_sof;
    logic               rd_req;
    logic               pixel_color;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_we;
    logic               mem_wdata;
    logic               mem_rdata;

    modport slave (
        input  clr_screen, wr_valid, wr_x, wr_y, wr_color, rd_sof, rd_req, mem_rdata,
        output clr_busy, wr_ready, pixel_color, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output clr_screen, wr_valid, wr_x, wr_y, wr_color, rd_sof, rd_req, mem_rdata,
        input  clr_busy, wr_ready, pixel_color, mem_addr, mem_we, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/fb_wr_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fb_wr_fifo
//  Description : 4-entry write buffer in front of the frame buffer write port.
//                Flush empties it; push at full is taken when a pop happens in
//                the same cycle. Only instantiated when FB_WR_FIFO_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_wr_fifo
    import fb_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         i_flush,
    input  logic         i_push,
    input  fb_wr_entry_t i_push_data,
    input  logic         i_pop,
    output fb_wr_entry_t o_head,
    output logic         o_empty,
    output logic         o_full
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] C_FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    fb_wr_entry_t     mem_q [FIFO_DEPTH];
    fb_wr_entry_t     mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == C_FULL_CNT);
    assign o_head  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        w_pop_ok  = i_pop & ~o_empty;
        w_push_ok = i_push & (~o_full | w_pop_ok);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push_ok) begin
                mem_d[wr_ptr_q] = i_push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (w_pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + (PTR_W+1)'(w_push_ok) - (PTR_W+1)'(w_pop_ok);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fb_arbiter
//  Description : Shares the single-port 1-bit frame buffer RAM between VGA
//                scan-out reads, the screen-clear sequencer and renderer
//                writes (priority in that order, one access per cycle).
//                Optional macro FB_WR_FIFO_EN adds a 4-entry write FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_arbiter
    import fb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    fb_arbiter_if.slave bus
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    fb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_in_clr_q, rd_in_clr_d;
    logic              pixel_color_q, pixel_color_d;

    logic [ADDR_W-1:0] w_rd_addr;
    fb_owner_e         w_owner;
    fb_wr_entry_t      w_wr_entry;
    logic              w_wr_go;
    logic              w_wr_ready;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_mem_we;
    logic              w_mem_wdata;

`ifdef FB_WR_FIFO_EN
    logic         w_fifo_empty;
    logic         w_fifo_full;
    logic         w_fifo_push;
    fb_wr_entry_t w_fifo_in;

    // Writes are buffered; the head retires whenever the RAM port is free.
    assign w_wr_ready  = ~w_fifo_full & (state_q == ST_IDLE);
    assign w_fifo_push = bus.wr_valid & w_wr_ready;
    assign w_fifo_in   = '{addr:     fb_lin_addr(bus.wr_x, bus.wr_y),
                           color:    bus.wr_color,
                           in_range: fb_in_range(bus.wr_x, bus.wr_y)};
    assign w_wr_go     = ~w_fifo_empty & (state_q == ST_IDLE) & ~bus.rd_req;

    fb_wr_fifo u_wr_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (bus.clr_screen),
        .i_push      (w_fifo_push),
        .i_push_data (w_fifo_in),
        .i_pop       (w_wr_go),
        .o_head      (w_wr_entry),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );
`else
    // Unbuffered: a write can only be accepted when the port is free now.
    assign w_wr_ready = (state_q == ST_IDLE) & ~bus.rd_req;
    assign w_wr_go    = bus.wr_valid & w_wr_ready;
    assign w_wr_entry = '{addr:     fb_lin_addr(bus.wr_x, bus.wr_y),
                          color:    bus.wr_color,
                          in_range: fb_in_range(bus.wr_x, bus.wr_y)};
`endif

    // sof forces this cycle's read to address 0.
    assign w_rd_addr = bus.rd_sof ? '0 : rd_addr_q;

    // Port ownership: read beats clear beats write.
    always_comb begin
        w_owner = OWN_NONE;
        if (bus.rd_req) begin
            w_owner = OWN_RD;
        end else if (state_q == ST_CLEAR) begin
            w_owner = OWN_CLR;
        end else if (w_wr_go) begin
            w_owner = OWN_WR;
        end
    end

    // RAM bus multiplexer driven by the current owner.
    always_comb begin
        w_mem_addr  = '0;
        w_mem_we    = 1'b0;
        w_mem_wdata = 1'b0;
        case (w_owner)
            OWN_RD: begin
                w_mem_addr = w_rd_addr;
            end
            OWN_CLR: begin
                w_mem_addr = clr_addr_q;
                w_mem_we   = 1'b1;
            end
            OWN_WR: begin
                w_mem_addr  = w_wr_entry.addr;
                w_mem_we    = w_wr_entry.in_range;
                w_mem_wdata = w_wr_entry.color;
            end
            default: begin
            end
        endcase
    end

    // Clear sequencer FSM next-state and clear address.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.clr_screen) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            ST_CLEAR: begin
                if (bus.clr_screen) begin
                    clr_addr_d = '0;
                end else if (!bus.rd_req) begin
                    if (clr_addr_q == C_LAST_ADDR) begin
                        state_d    = ST_IDLE;
                        clr_addr_d = '0;
                    end else begin
                        clr_addr_d = clr_addr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Scan-out address and the two-stage pixel return path.
    always_comb begin
        rd_addr_d = rd_addr_q;
        if (bus.rd_req) begin
            rd_addr_d = (w_rd_addr == C_LAST_ADDR) ? '0 : w_rd_addr + 1'b1;
        end else if (bus.rd_sof) begin
            rd_addr_d = '0;
        end
        rd_pend_d     = bus.rd_req;
        rd_in_clr_d   = (state_q == ST_CLEAR);
        pixel_color_d = rd_pend_q & ~rd_in_clr_q & bus.mem_rdata;
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rd_addr_q     <= '0;
            clr_addr_q    <= '0;
            rd_pend_q     <= 1'b0;
            rd_in_clr_q   <= 1'b0;
            pixel_color_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            clr_addr_q    <= clr_addr_d;
            rd_pend_q     <= rd_pend_d;
            rd_in_clr_q   <= rd_in_clr_d;
            pixel_color_q <= pixel_color_d;
        end
    end

    // The RAM bus and handshake are combinational, so hold them quiet in reset.
    assign bus.mem_addr    = reset ? '0 : w_mem_addr;
    assign bus.mem_we      = w_mem_we & ~reset;
    assign bus.mem_wdata   = w_mem_wdata & ~reset;
    assign bus.wr_ready    = w_wr_ready & ~reset;
    assign bus.clr_busy    = (state_q == ST_CLEAR);
    assign bus.pixel_color = pixel_color_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_arbiter
//  Description : Self-checking bench for fb_arbiter. Holds a RAM model and a
//                rule-level reference (frame contents, scan pointer, clear
//                progress, pixel return queue).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_arbiter;
    import fb_pkg::*;

    logic clk;
    logic reset;
    fb_arbiter_if bus ();

    fb_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with one-cycle read latency.
    logic ram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    // Reference state.
    bit fb [FB_DEPTH];
    int rp;
    bit in_clr;
    int ca;
    bit pix_q[$];

    int passed;
    int total;
    int obs_addr;
    bit obs_we, obs_rdy, obs_busy, obs_pix;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        rp = 0;
        in_clr = 1'b0;
        ca = 0;
        pix_q = '{1'b0, 1'b0};
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.rd_req = 1'b0; bus.rd_sof = 1'b0; bus.clr_screen = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_x = 5'd3; bus.wr_y = 5'd2; bus.wr_color = 1'b1;
        #1;
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_clr_busy", bus.clr_busy, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_pixel", bus.pixel_color, 0);
        @(negedge clk);
        reset = 1'b0;
        bus.wr_valid = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive, check against the rules, then advance the model.
    task automatic cyc(input bit rq, input bit sof, input bit v, input int x,
                       input int y, input bit c, input bit clr);
        bit e_we, e_rdy, e_wd, inr, rd_val;
        int e_addr, wa;
        @(negedge clk);
        bus.rd_req = rq; bus.rd_sof = sof; bus.wr_valid = v;
        bus.wr_x = COORD_W'(x); bus.wr_y = COORD_W'(y); bus.wr_color = c;
        bus.clr_screen = clr;
        #1;
        e_we = 1'b0; e_rdy = 1'b0; e_wd = 1'b0; e_addr = -1;
        inr = (x < FB_W) && (y < FB_H);
        wa = x + FB_W * y;
        if (rq) begin
            e_addr = sof ? 0 : rp;
        end else if (in_clr) begin
            e_we = 1'b1;
            e_addr = ca;
        end else begin
            e_rdy = 1'b1;
            if (v && inr) begin
                e_we = 1'b1; e_addr = wa; e_wd = c;
            end
        end
        obs_addr = int'(bus.mem_addr); obs_we = bus.mem_we; obs_rdy = bus.wr_ready;
        obs_busy = bus.clr_busy; obs_pix = bus.pixel_color;
        chk("wr_ready", obs_rdy, e_rdy);
        chk("mem_we", obs_we, e_we);
        chk("clr_busy", obs_busy, in_clr);
        chk("pixel_color", obs_pix, pix_q[0]);
        if (e_addr >= 0) chk("mem_addr", obs_addr, e_addr);
        if (e_we) chk("mem_wdata", bus.mem_wdata, e_wd);
        @(posedge clk);
        rd_val = (rq && !in_clr) ? fb[e_addr] : 1'b0;
        void'(pix_q.pop_front());
        pix_q.push_back(rd_val);
        if (e_we) fb[e_addr] = e_wd;
        if (rq) rp = ((sof ? 0 : rp) + 1) % FB_DEPTH;
        else if (sof) rp = 0;
        if (in_clr) begin
            if (clr) ca = 0;
            else if (!rq) begin
                if (ca == FB_DEPTH - 1) begin in_clr = 1'b0; ca = 0; end
                else ca++;
            end
        end else if (clr) begin
            in_clr = 1'b1; ca = 0;
        end
    endtask

    initial begin
        int cnt, ones, pos;
        passed = 0; total = 0;
        reset = 1'b1;
        bus.rd_req = 1'b0; bus.rd_sof = 1'b0; bus.clr_screen = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_color = 1'b0;
        for (int i = 0; i < FB_DEPTH; i++) fb[i] = 1'b0;
        model_reset();
        do_reset();

        // Full clear with no reads; writer held valid to see it stalled.
        cyc(0, 0, 0, 0, 0, 0, 1);
        cnt = 0;
        for (int i = 0; i < 402; i++) begin
            cyc(0, 0, 1, 1, 1, 0, 0);
            cnt += int'(obs_busy);
        end
        chk("clear_len", cnt, 400);

        // Single pixel write then a full scan.
        cyc(0, 0, 1, 3, 2, 1, 0);
        chk("wr_3_2_addr", obs_addr, 43);
        chk("wr_3_2_we", obs_we, 1);
        ones = 0; pos = -1;
        for (int i = 0; i < 402; i++) begin
            cyc(i < 400, i == 0, 0, 0, 0, 0, 0);
            if (obs_pix) begin ones++; pos = i - 1; end
        end
        chk("scan_ones", ones, 1);
        chk("scan_pos", pos, 44);

        // Collision: writer blocked while reading, completes when read drops.
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 1, 7, 7, 1, 0);
            cnt += int'(obs_we) + int'(obs_rdy);
        end
        chk("coll_blocked", cnt, 0);
        cyc(0, 0, 1, 7, 7, 1, 0);
        chk("coll_done", obs_we, 1);

        // Out-of-range write: handshake only.
        cyc(0, 0, 1, 20, 5, 1, 0);
        chk("oor_ready", obs_rdy, 1);
        chk("oor_we", obs_we, 0);

        // Clear with alternating reads takes twice as long.
        cyc(0, 0, 0, 0, 0, 0, 1);
        cnt = 0;
        for (int i = 0; i < 810; i++) begin
            cyc(i % 2 == 0, 0, 0, 0, 0, 0, 0);
            cnt += int'(obs_busy);
        end
        chk("clear_ilv_len", cnt, 800);

        // Reset in the middle of a clear, then restart from address 0.
        cyc(0, 0, 1, 5, 5, 1, 0);
        cyc(0, 0, 1, 19, 19, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 50; i++) cyc(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("rst_abort_busy", obs_busy, 0);
        chk("rst_abort_we", obs_we, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("clr_restart_addr", obs_addr, 0);
        for (int i = 0; i < 402; i++) cyc(0, 0, 0, 0, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 2500; i++) begin
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0,
                $urandom_range(0, 3) != 0, int'($urandom_range(0, 23)),
                int'($urandom_range(0, 23)), $urandom_range(0, 1) == 1,
                $urandom_range(0, 299) == 0);
        end

        // Let any clear finish, then read the whole frame back.
        for (int i = 0; i < 810 && in_clr; i++) cyc(0, 0, 0, 0, 0, 0, 0);
        chk("final_idle", int'(in_clr), 0);
        for (int i = 0; i < 402; i++) cyc(i < 400, i == 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
